// File: rtl/board_io_pkg.sv
// ---------------------------------------------------------------------------
// board_io_pkg
// Shared constants and helpers for the board I/O blocks. The input debouncer
// and the LED / seven-segment output logic both import this package.
//
// Contents:
//   BOARD_SW_WIDTH         - number of slide switches + push-buttons
//   DEBOUNCE_TICK_DIV      - mclk cycles per debounce sample tick
//   DEBOUNCE_STABLE_TICKS  - consecutive differing ticks needed to accept a level
//   clog2_int()            - ceiling log2, used for counter widths
// ---------------------------------------------------------------------------
package board_io_pkg;

    localparam int BOARD_SW_WIDTH        = 16;
    localparam int DEBOUNCE_TICK_DIV     = 100000;
    localparam int DEBOUNCE_STABLE_TICKS = 20;

    // Ceiling log2 for sizing counters. The result is never below 1, so a
    // counter that only ever holds 0 still gets a legal one-bit vector.
    function automatic int clog2_int(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// ---------------------------------------------------------------------------
// debounce_bit
// Debounces one raw board input. The raw pin goes through a two-flop
// synchronizer. It is then compared with the accepted level on every sample
// tick. The accepted level flips only after STABLE_TICKS consecutive ticks
// have all seen the opposite level. A flip produces a one-cycle registered
// rise or fall pulse in the same cycle that sw_db changes.
//
// Ports:
//   mclk   in  - clock, all state on rising edge
//   rst_n  in  - asynchronous active-low reset
//   tick   in  - one-cycle sample strobe from the shared prescaler
//   sw_in  in  - raw asynchronous pin
//   sw_db  out - debounced level
//   rise   out - one-cycle pulse on an accepted 0->1
//   fall   out - one-cycle pulse on an accepted 1->0
// ---------------------------------------------------------------------------
module debounce_bit #(
    parameter int STABLE_TICKS = 20,
    parameter int CNT_W        = 5
) (
    input  logic mclk,
    input  logic rst_n,
    input  logic tick,
    input  logic sw_in,
    output logic sw_db,
    output logic rise,
    output logic fall
);

    logic             sync_meta;
    logic             sync;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchronizer. The first stage may go metastable; only the
    // second stage is used by the debounce logic.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= sw_in;
            sync      <= sync_meta;
        end
    end

    // Mismatch counter and accepted level. Any tick that sees agreement
    // restarts the count, so a bounce back to the old level costs the whole
    // run. The pulses default low every cycle, which keeps them exactly one
    // cycle wide. Only one of rise or fall can be set on a given acceptance.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            sw_db <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (tick) begin
                if (sync == sw_db) begin
                    cnt <= '0;
                end else if (cnt == CNT_W'(STABLE_TICKS - 1)) begin
                    sw_db <= sync;
                    cnt   <= '0;
                    rise  <= sync;
                    fall  <= ~sync;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/board_input_debounce.sv
// ---------------------------------------------------------------------------
// board_input_debounce
// Board-pin front end for the switches and buttons. It holds one shared
// sample-tick prescaler, one debounce_bit per input, and a sticky event mask.
// The event mask lets slow consumers collect rise/fall activity and then
// clear it with a valid/ack handshake.
//
// Ports:
//   mclk      in  - clock
//   rst_n     in  - asynchronous active-low reset
//   sw_in     in  [WIDTH] raw pins
//   sw_db     out [WIDTH] debounced levels
//   rise      out [WIDTH] one-cycle pulses on accepted 0->1
//   fall      out [WIDTH] one-cycle pulses on accepted 1->0
//   evt_valid out - evt_mask is nonzero
//   evt_mask  out [WIDTH] sticky OR of rise|fall since last accepted ack
//   evt_ack   in  - clears the mask; only honoured while evt_valid is high
// ---------------------------------------------------------------------------
module board_input_debounce
    import board_io_pkg::*;
#(
    parameter int WIDTH        = BOARD_SW_WIDTH,
    parameter int TICK_DIV     = DEBOUNCE_TICK_DIV,
    parameter int STABLE_TICKS = DEBOUNCE_STABLE_TICKS
) (
    input  logic             mclk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             evt_valid,
    output logic [WIDTH-1:0] evt_mask,
    input  logic             evt_ack
);

    localparam int DIV_W = clog2_int(TICK_DIV);
    localparam int CNT_W = clog2_int(STABLE_TICKS + 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [WIDTH-1:0] next_mask;

    // The tick is decoded from the counter's terminal value, so it is high
    // during the cycle whose count equals TICK_DIV-1.
    assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));

    // Shared prescaler. It wraps to zero on the terminal count.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // One independent debouncer per input bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_TICKS (STABLE_TICKS),
            .CNT_W        (CNT_W)
        ) u_bit (
            .mclk  (mclk),
            .rst_n (rst_n),
            .tick  (tick),
            .sw_in (sw_in[i]),
            .sw_db (sw_db[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

    // Edges merge in after any clear. An edge that arrives in the same
    // cycle as an accepted ack therefore survives into the next mask.
    always_comb begin
        next_mask = ((evt_valid && evt_ack) ? '0 : evt_mask) | rise | fall;
    end

    // evt_valid is registered from the same next value as the mask, so the
    // two always change together.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            evt_mask  <= '0;
            evt_valid <= 1'b0;
        end else begin
            evt_mask  <= next_mask;
            evt_valid <= |next_mask;
        end
    end

endmodule

// File: tb/tb_board_input_debounce.sv
// ---------------------------------------------------------------------------
// tb_board_input_debounce
// Self-checking bench for board_input_debounce with TICK_DIV=4,
// STABLE_TICKS=3 and WIDTH=16. A window-based reference model predicts every
// output on every cycle. Directed scenarios add hand-computed literal checks
// on top of the model.
// ---------------------------------------------------------------------------
module tb_board_input_debounce;

    localparam int W = 16;
    localparam int D = 4;
    localparam int S = 3;

    logic         mclk;
    logic         rst_n;
    logic [W-1:0] sw_in;
    logic [W-1:0] sw_db;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         evt_valid;
    logic [W-1:0] evt_mask;
    logic         evt_ack;

    int tests_run;
    int tests_failed;
    bit check_en;

    board_input_debounce #(
        .WIDTH        (W),
        .TICK_DIV     (D),
        .STABLE_TICKS (S)
    ) dut (
        .mclk      (mclk),
        .rst_n     (rst_n),
        .sw_in     (sw_in),
        .sw_db     (sw_db),
        .rise      (rise),
        .fall      (fall),
        .evt_valid (evt_valid),
        .evt_mask  (evt_mask),
        .evt_ack   (evt_ack)
    );

    // Free-running clock with a period of 10 time units.
    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    // -----------------------------------------------------------------------
    // Reference model.
    // Each bit keeps a window of the synchronized level seen on its most
    // recent S ticks. The accepted level flips when the window is full and
    // every entry in it differs from the current accepted level. The
    // synchronizer is a two-deep pipe. Tick n falls on every D-th edge after
    // reset release.
    // -----------------------------------------------------------------------
    logic [W-1:0] m_pipe0, m_pipe1, m_db, m_rise, m_fall, m_mask;
    logic         m_valid;
    logic [S-1:0] m_hist [W];
    int           m_edges;
    int           m_ticks;
    logic [W-1:0] m_seen, m_nr, m_nf, m_nm;

    always @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            m_pipe0 = '0; m_pipe1 = '0; m_db = '0; m_rise = '0; m_fall = '0;
            m_mask = '0; m_valid = 1'b0; m_edges = 0; m_ticks = 0;
            for (int b = 0; b < W; b++) m_hist[b] = '0;
        end else begin
            m_seen  = m_pipe1;
            m_pipe1 = m_pipe0;
            m_pipe0 = sw_in;
            m_edges = m_edges + 1;
            m_nr = '0;
            m_nf = '0;
            if (m_edges % D == 0) begin
                m_ticks = m_ticks + 1;
                for (int b = 0; b < W; b++) begin
                    m_hist[b] = {m_hist[b][S-2:0], m_seen[b]};
                    if (m_ticks >= S && m_hist[b] == {S{~m_db[b]}}) begin
                        if (m_db[b]) m_nf[b] = 1'b1;
                        else         m_nr[b] = 1'b1;
                    end
                end
                m_db = m_db ^ (m_nr | m_nf);
            end
            m_nm    = ((m_valid && evt_ack) ? '0 : m_mask) | m_rise | m_fall;
            m_mask  = m_nm;
            m_valid = |m_nm;
            m_rise  = m_nr;
            m_fall  = m_nf;
        end
    end

    // Shared comparison task. It keeps the run and fail counters.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run = tests_run + 1;
        if (actual !== expected) begin
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
        end
    endtask

    // Every-cycle comparison against the model, sampled just after the edge.
    always @(posedge mclk) begin
        #1;
        if (check_en) begin
            checkOutput("model_sw_db",     32'(sw_db),     32'(m_db));
            checkOutput("model_rise",      32'(rise),      32'(m_rise));
            checkOutput("model_fall",      32'(fall),      32'(m_fall));
            checkOutput("model_evt_mask",  32'(evt_mask),  32'(m_mask));
            checkOutput("model_evt_valid", 32'(evt_valid), 32'(m_valid));
        end
    end

    // Drives the input pins and the ack line. It is always called on a
    // falling edge.
    task automatic applyStimulus(input logic [W-1:0] sw, input logic ack);
        sw_in   = sw;
        evt_ack = ack;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge mclk);
    endtask

    // Waits on falling edges until a selected rise (or fall) bit pulses.
    // Running out of budget counts as a failed comparison.
    task automatic wait_pulse(input logic [W-1:0] sel, input bit want_rise,
                              input int budget, output int cycles);
        bit hit;
        hit    = 1'b0;
        cycles = 0;
        while (!hit && cycles < budget) begin
            @(negedge mclk);
            cycles = cycles + 1;
            if (((want_rise ? rise : fall) & sel) != '0) hit = 1'b1;
        end
        if (!hit) checkOutput("pulse_timeout", 32'(cycles), 32'(budget + 1));
    endtask

    // Clears the event mask with a one-cycle ack.
    task automatic clear_events();
        applyStimulus(sw_in, 1'b1);
        step(1);
        applyStimulus(sw_in, 1'b0);
        step(1);
    endtask

    // Watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int pulses;
        tests_run    = 0;
        tests_failed = 0;
        check_en     = 1'b1;
        rst_n        = 1'b0;
        applyStimulus(16'hFFFF, 1'b0);

        // Reset with all pins high: everything reads 0.
        step(3);
        checkOutput("reset_sw_db",  32'(sw_db),     32'h0);
        checkOutput("reset_rise",   32'(rise),      32'h0);
        checkOutput("reset_fall",   32'(fall),      32'h0);
        checkOutput("reset_mask",   32'(evt_mask),  32'h0);
        checkOutput("reset_valid",  32'(evt_valid), 32'h0);

        // Release: the first accepting tick lands on edge 12 (ticks 4, 8, 12).
        rst_n = 1'b1;
        wait_pulse(16'hFFFF, 1'b1, 20, cyc);
        checkOutput("release_rise_cycle", 32'(cyc),  32'd12);
        checkOutput("release_rise",       32'(rise), 32'hFFFF);
        checkOutput("release_sw_db",      32'(sw_db), 32'hFFFF);
        step(1);
        checkOutput("release_rise_gone", 32'(rise),      32'h0);
        checkOutput("release_mask",      32'(evt_mask),  32'hFFFF);
        checkOutput("release_valid",     32'(evt_valid), 32'h1);
        clear_events();
        checkOutput("ack_clear_mask",  32'(evt_mask),  32'h0);
        checkOutput("ack_clear_valid", 32'(evt_valid), 32'h0);

        // Drive all pins low, then raise bit 5 so that it can fall later.
        applyStimulus(16'h0000, 1'b0);
        wait_pulse(16'hFFFF, 1'b0, 40, cyc);
        checkOutput("all_fall", 32'(fall), 32'hFFFF);
        step(2);
        clear_events();
        applyStimulus(16'h0020, 1'b0);
        wait_pulse(16'h0020, 1'b1, 40, cyc);
        step(2);
        clear_events();

        // Single clean rise on bit 3.
        applyStimulus(16'h0028, 1'b0);
        wait_pulse(16'h0008, 1'b1, 40, cyc);
        checkOutput("bit3_rise",  32'(rise),  32'h0008);
        checkOutput("bit3_fall",  32'(fall),  32'h0000);
        checkOutput("bit3_sw_db", 32'(sw_db), 32'h0028);
        step(1);
        checkOutput("bit3_rise_one_cycle", 32'(rise),     32'h0);
        checkOutput("bit3_mask",           32'(evt_mask), 32'h0008);

        // Ack in the same cycle as fall[5]: the new edge survives the clear.
        applyStimulus(16'h0008, 1'b0);
        wait_pulse(16'h0020, 1'b0, 40, cyc);
        checkOutput("race_fall5", 32'(fall), 32'h0020);
        applyStimulus(16'h0008, 1'b1);
        step(1);
        applyStimulus(16'h0008, 1'b0);
        checkOutput("race_mask",  32'(evt_mask),  32'h0020);
        checkOutput("race_valid", 32'(evt_valid), 32'h1);
        clear_events();
        checkOutput("second_ack_mask",  32'(evt_mask),  32'h0);
        checkOutput("second_ack_valid", 32'(evt_valid), 32'h0);
        clear_events();
        checkOutput("idle_ack_mask",  32'(evt_mask),  32'h0);
        checkOutput("idle_ack_valid", 32'(evt_valid), 32'h0);

        // Bounce on bit 0: high 6 cycles, low 2, then steady high.
        pulses = 0;
        applyStimulus(16'h0009, 1'b0);
        for (int i = 0; i < 6; i++) begin step(1); if (rise[0]) pulses++; end
        applyStimulus(16'h0008, 1'b0);
        for (int i = 0; i < 2; i++) begin step(1); if (rise[0]) pulses++; end
        applyStimulus(16'h0009, 1'b0);
        for (int i = 0; i < 30; i++) begin step(1); if (rise[0]) pulses++; end
        checkOutput("bounce_rise_count", 32'(pulses), 32'd1);
        checkOutput("bounce_sw_db",      32'(sw_db),  32'h0009);
        clear_events();

        // Bits 15 and 1 flip together.
        applyStimulus(16'h800B, 1'b0);
        wait_pulse(16'h8002, 1'b1, 40, cyc);
        checkOutput("simul_rise", 32'(rise), 32'h8002);
        step(1);
        checkOutput("simul_mask", 32'(evt_mask), 32'h8002);
        clear_events();

        // Reset in the middle of a count on bit 7. The pulse then needs
        // three fresh ticks after release, and every high pin rises together.
        applyStimulus(16'h808B, 1'b0);
        step(10);
        checkOutput("midcount_no_rise", 32'(sw_db), 32'h800B);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        wait_pulse(16'h0080, 1'b1, 30, cyc);
        checkOutput("midcount_rise_cycle", 32'(cyc),  32'd12);
        checkOutput("midcount_rise_all",   32'(rise), 32'h808B);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin step(1); if (rise[7]) pulses++; end
        checkOutput("midcount_single_pulse", 32'(pulses), 32'd0);

        check_en = 1'b0;
        step(1);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/board_input_debounce.md
# board_input_debounce

Input-side companion to the board LED/seven-segment output logic. It samples the raw slide switches and push-buttons, synchronizes and debounces each bit, and produces clean levels plus single-cycle rise/fall pulses. It also keeps a sticky change mask with a valid/ack handshake, so slower consumer logic cannot miss an edge. It sits between the board pins and any user logic on the `mclk` domain.

## Interface
- `WIDTH`, 16: number of input bits debounced.
- `TICK_DIV`, 100000: `mclk` cycles per sample tick; must be ≥ 2.
- `STABLE_TICKS`, 20: consecutive mismatching ticks required to accept a new level; must be ≥ 1.

Ports (name, direction, width, meaning):
- `mclk` in 1: the single clock; all state is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sw_in` in WIDTH: raw, asynchronous switch/button pins.
- `sw_db` out WIDTH: debounced stable level.
- `rise` out WIDTH: one-cycle pulse when a `sw_db` bit goes 0→1.
- `fall` out WIDTH: one-cycle pulse when a `sw_db` bit goes 1→0.
- `evt_valid` out 1: high while `evt_mask` is nonzero.
- `evt_mask` out WIDTH: sticky OR of `rise|fall` since the last accepted ack.
- `evt_ack` in 1: consumer acknowledge. It is effective only when `evt_valid` is high.

## Operation
- **Reset.** While `rst_n`=0, all of the following are 0: synchronizer flops, tick counter, per-bit counters, `sw_db`, `rise`, `fall`, `evt_mask`, and `evt_valid`. Reset asserted mid-debounce discards any partial count. Inputs that are high at reset release produce a `rise` once debounced.
- **Synchronizer.** Each bit passes through a 2-flop synchronizer to give `sync`.
- **Tick prescaler.**
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - `tick`=1 for one cycle when the count equals TICK_DIV-1.
  - The prescaler is shared by all bits.
- **Per-bit debounce.** Each bit has a counter of width clog2(STABLE_TICKS+1). On a tick:
  - If `sync`==`sw_db`: counter ← 0.
  - Else, if counter==STABLE_TICKS-1: `sw_db` ← `sync`, counter ← 0, and the matching `rise` or `fall` bit is set for the next cycle only.
  - Else: counter ← counter+1.
  - Between ticks, counters hold.
- **Glitch filtering.** A bounce that returns to the old level on any tick restarts the count. Changes that occur entirely between two ticks are never seen.
- **Pulse outputs.** `rise`/`fall` are registered and high for exactly one `mclk` cycle. They are never both high on the same bit.
- **Event capture.**
  - Next mask = (ack_taken ? 0 : `evt_mask`) | `rise` | `fall`, where ack_taken = `evt_valid` & `evt_ack`.
  - `evt_valid` is the registered OR-reduction of that next value, so it is coincident with `evt_mask`.
  - If an edge arrives in the same cycle as an accepted ack, it survives, and `evt_valid` stays high.
  - An ack while `evt_valid`=0 is ignored.
- **Independence.** Bits are independent. Several bits may flip on the same tick; their pulses are then simultaneous and OR into `evt_mask` together.

## Timing
- The synchronizer adds 2 cycles.
- **Minimum acceptance delay.** Measured from the first tick that sees the new `sync` level to the `sw_db` update, the delay is (STABLE_TICKS-1)·TICK_DIV + 1 cycles.
- **Worst case.** From a pin change to the `sw_db` update: 2 + STABLE_TICKS·TICK_DIV + 1 cycles.
- **Alignment.**
  - `rise`/`fall` assert in the same cycle that `sw_db` changes.
  - `evt_mask`/`evt_valid` update one cycle later.
  - Ack takes effect on the next edge: the mask clears in the cycle after `evt_valid`&`evt_ack`.
- **Outputs.** Fully registered, with no combinational path from inputs to outputs.

## Structure
- **Shared package `board_io_pkg`.** Holds the default constants `BOARD_SW_WIDTH`=16, `DEBOUNCE_TICK_DIV`, and `DEBOUNCE_STABLE_TICKS`, plus a clog2 helper function. The LED/segment output blocks use the same package.
- **Sub-module `debounce_bit`.** One instance per bit, created by a generate loop. It contains the synchronizer, counter, stable flop, and rise/fall flops, and takes `tick` as an input.
- **Top level.** Holds the shared prescaler and the event-capture register.

## Test plan
All scenarios use TICK_DIV=4, STABLE_TICKS=3, WIDTH=16.

1. **Reset.** Hold `rst_n`=0 with `sw_in`=16'hFFFF → all outputs are 0. Release reset → `sw_db` becomes FFFF within 2+3·4+1=15 cycles, `rise`=FFFF for one cycle, and `evt_mask`=FFFF with `evt_valid`=1 on the next cycle.
2. **Single clean edge.** Change `sw_in[3]` 0→1 and hold → exactly one `rise[3]` pulse, `sw_db[3]`=1, no `fall`, and `evt_mask`=0008.
3. **Bounce.** Toggle `sw_in[0]` high for 6 cycles, low for 2, then high steadily → no pulse until 3 consecutive mismatching ticks are seen; exactly one `rise[0]` in total.
4. **Ack/merge race.** With `evt_mask`=0008, assert `evt_ack` in the same cycle as a `fall[5]` pulse → the next `evt_mask`=0020 and `evt_valid` stays 1. A second ack → mask 0000, `evt_valid`=0. An ack with `evt_valid`=0 → no change.
5. **Simultaneous bits.** Flip bits 15 and 1 in the same cycle → `rise[15]` and `rise[1]` pulse in the same cycle; `evt_mask`=8002.
6. **Reset mid-count.** Drive a new level for 2 ticks, pulse `rst_n` low for 1 cycle, then hold the level → no pulse before a full 3 fresh ticks after release; then a single pulse.
